// File: rtl/bram_xfer_ctrl.sv
// BRAM-to-BRAM block copy controller: streams L words from a source BRAM to a destination BRAM.
// Optional running checksum output enabled by defining BRAM_XFER_CHECKSUM_EN.
module bram_xfer_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                start,
   input  logic [ADDR_W:0]     length,
   input  logic                abort,
   output logic [ADDR_W-1:0]   rd_addr,
   output logic                rd_en,
   input  logic [DATA_W-1:0]   rd_data,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]   wr_data,
   output logic                wr_en,
   output logic [DATA_W/8-1:0] wr_we,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W:0]     word_count
`ifdef BRAM_XFER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]   checksum
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_W:0] MAX_LEN    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [1:0]      DRAIN_INIT = 2'(RD_LAT - 1);

   state_t              r_state;
   state_t              w_nextState;
   logic [ADDR_W:0]     r_len;
   logic [ADDR_W-1:0]   r_rdAddr;
   logic [1:0]          r_drainCnt;
   logic [RD_LAT-1:0]   r_vldPipe;
   logic [ADDR_W-1:0]   r_addrPipe [RD_LAT];
   logic [ADDR_W:0]     r_wordCount;
   logic [ADDR_W:0]     w_lenClamp;
   logic                w_accept;
   logic                w_abortNow;
   logic                w_lastRead;

   assign w_lenClamp = (length > MAX_LEN) ? MAX_LEN : length;
   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_abortNow = abort && ((r_state == S_READ) || (r_state == S_DRAIN));
   assign w_lastRead = ({1'b0, r_rdAddr} == (r_len - (ADDR_W+1)'(1)));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      rd_en       = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_nextState = (w_lenClamp == '0) ? S_DONE : S_READ;
         end
         S_READ: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            if (abort)           w_nextState = S_IDLE;
            else if (w_lastRead) w_nextState = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (abort)                    w_nextState = S_IDLE;
            else if (r_drainCnt == 2'd0)  w_nextState = S_DONE;
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // The valid/address pipeline mirrors the source BRAM latency; abort flushes it.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_len       <= '0;
         r_rdAddr    <= '0;
         r_drainCnt  <= '0;
         r_vldPipe   <= '0;
         r_wordCount <= '0;
         for (int i = 0; i < RD_LAT; i++) r_addrPipe[i] <= '0;
      end else begin
         if (w_accept) begin
            r_len    <= w_lenClamp;
            r_rdAddr <= '0;
         end else if ((r_state == S_READ) && !w_lastRead) begin
            r_rdAddr <= r_rdAddr + (ADDR_W)'(1);
         end

         if (r_state == S_READ)
            r_drainCnt <= DRAIN_INIT;
         else if ((r_state == S_DRAIN) && (r_drainCnt != 2'd0))
            r_drainCnt <= r_drainCnt - 2'd1;

         r_vldPipe[0]  <= rd_en && !w_abortNow;
         r_addrPipe[0] <= r_rdAddr;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vldPipe[i]  <= r_vldPipe[i-1] && !w_abortNow;
            r_addrPipe[i] <= r_addrPipe[i-1];
         end

         if (w_accept)   r_wordCount <= '0;
         else if (wr_en) r_wordCount <= r_wordCount + (ADDR_W+1)'(1);
      end
   end

   assign rd_addr    = r_rdAddr;
   assign wr_en      = r_vldPipe[RD_LAT-1];
   assign wr_addr    = r_addrPipe[RD_LAT-1];
   assign wr_data    = wr_en ? rd_data : '0;
   assign wr_we      = {(DATA_W/8){wr_en}};
   assign word_count = r_wordCount;

`ifdef BRAM_XFER_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)    r_checksum <= '0;
      else if (w_accept) r_checksum <= '0;
      else if (wr_en) r_checksum <= r_checksum + wr_data;
   end

   assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_bram_xfer_ctrl.sv
// Scoreboard bench for bram_xfer_ctrl: two instances (RD_LAT=1 and RD_LAT=2) share stimulus.
// Checksum checks are active when BRAM_XFER_CHECKSUM_EN is defined.
module tb_bram_xfer_ctrl;

   localparam int AW = 10;
   localparam int DW = 32;

   typedef struct {int cyc; int addr; logic [DW-1:0] data;} wr_t;
   typedef struct {int cyc; int wc; logic [DW-1:0] cs;} dn_t;
   typedef struct {int cyc; int k; logic busy; logic rdEn; logic wrEn; logic done; int wc; bit zeros;} snap_t;
   typedef struct packed {
      logic busy; logic rdEn; logic wrEn; logic done;
      logic [AW-1:0] rdAddr; logic [AW-1:0] wrAddr; logic [DW-1:0] wrData;
      logic [3:0] wrWe; logic [AW:0] wc; logic [DW-1:0] cs;
   } obs_t;

   logic clock, resetn, start, abort;
   logic [AW:0] length;
   logic [AW-1:0] rdAddr0, rdAddr1, wrAddr0, wrAddr1;
   logic rdEn0, rdEn1, wrEn0, wrEn1, busy0, busy1, done0, done1;
   logic [DW-1:0] rdData0, rdData1, wrData0, wrData1, cs0, cs1, stage1;
   logic [3:0] wrWe0, wrWe1;
   logic [AW:0] wordCount0, wordCount1;
   logic [DW-1:0] mem [1024];

   int cyc = 0;
   int compared = 0;
   int mismatched = 0;
   bit endReq = 0;
   bit endAck = 0;
   wr_t wq0[$], wq1[$];
   dn_t dq0[$], dq1[$];
   snap_t snapQ[$];
   obs_t o0, o1;

   bram_xfer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u0 (
      .clock(clock), .resetn(resetn), .start(start), .length(length), .abort(abort),
      .rd_addr(rdAddr0), .rd_en(rdEn0), .rd_data(rdData0),
      .wr_addr(wrAddr0), .wr_data(wrData0), .wr_en(wrEn0), .wr_we(wrWe0),
      .busy(busy0), .done(done0), .word_count(wordCount0)
`ifdef BRAM_XFER_CHECKSUM_EN
      , .checksum(cs0)
`endif
   );

   bram_xfer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u1 (
      .clock(clock), .resetn(resetn), .start(start), .length(length), .abort(abort),
      .rd_addr(rdAddr1), .rd_en(rdEn1), .rd_data(rdData1),
      .wr_addr(wrAddr1), .wr_data(wrData1), .wr_en(wrEn1), .wr_we(wrWe1),
      .busy(busy1), .done(done1), .word_count(wordCount1)
`ifdef BRAM_XFER_CHECKSUM_EN
      , .checksum(cs1)
`endif
   );

`ifndef BRAM_XFER_CHECKSUM_EN
   assign cs0 = '0;
   assign cs1 = '0;
`endif

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // Source BRAM models with one and two cycles of read latency.
   always @(posedge clock) if (rdEn0) rdData0 <= mem[rdAddr0];
   always @(posedge clock) begin
      if (rdEn1) stage1 <= mem[rdAddr1];
      rdData1 <= stage1;
   end

   task automatic checkOutput(input int k, input obs_t o);
      int nW, nD;
      wr_t fW, e;
      dn_t fD, d;
      bit csOk;
      nW = (k == 0) ? wq0.size() : wq1.size();
      nD = (k == 0) ? dq0.size() : dq1.size();
      if (nW > 0) fW = (k == 0) ? wq0[0] : wq1[0];
      if (nD > 0) fD = (k == 0) ? dq0[0] : dq1[0];
      if (o.wrEn) begin
         compared++;
         if (nW == 0) begin
            mismatched++;
            $display("[TB] FAIL write%0d: unexpected write cyc=%0d addr=%0d data=%h, required none", k, cyc, o.wrAddr, o.wrData);
         end else begin
            if (k == 0) e = wq0.pop_front(); else e = wq1.pop_front();
            if (e.cyc != cyc || o.wrAddr != AW'(e.addr) || o.wrData != e.data || o.wrWe != 4'hF) begin
               mismatched++;
               $display("[TB] FAIL write%0d: got cyc=%0d addr=%0d data=%h we=%h, required cyc=%0d addr=%0d data=%h we=f",
                        k, cyc, o.wrAddr, o.wrData, o.wrWe, e.cyc, e.addr, e.data);
            end
         end
      end else if (nW > 0 && fW.cyc < cyc) begin
         compared++;
         mismatched++;
         if (k == 0) void'(wq0.pop_front()); else void'(wq1.pop_front());
         $display("[TB] FAIL write%0d: no write seen, required cyc=%0d addr=%0d", k, fW.cyc, fW.addr);
      end
      if (o.done) begin
         compared++;
         if (nD == 0) begin
            mismatched++;
            $display("[TB] FAIL done%0d: unexpected done at cyc=%0d, required none", k, cyc);
         end else begin
            if (k == 0) d = dq0.pop_front(); else d = dq1.pop_front();
            csOk = 1'b1;
`ifdef BRAM_XFER_CHECKSUM_EN
            csOk = (o.cs == d.cs);
`endif
            if (d.cyc != cyc || o.wc != (AW+1)'(d.wc) || !csOk) begin
               mismatched++;
               $display("[TB] FAIL done%0d: got cyc=%0d count=%0d csum=%h, required cyc=%0d count=%0d csum=%h",
                        k, cyc, o.wc, o.cs, d.cyc, d.wc, d.cs);
            end
         end
      end else if (nD > 0 && fD.cyc < cyc) begin
         compared++;
         mismatched++;
         if (k == 0) void'(dq0.pop_front()); else void'(dq1.pop_front());
         $display("[TB] FAIL done%0d: no done seen, required cyc=%0d", k, fD.cyc);
      end
   endtask

   task automatic checkSnap(input snap_t s, input obs_t o);
      compared++;
      if (o.busy != s.busy || o.rdEn != s.rdEn || o.wrEn != s.wrEn || o.done != s.done ||
          o.wc != (AW+1)'(s.wc) ||
          (s.zeros && (o.rdAddr != '0 || o.wrAddr != '0 || o.wrData != '0 || o.wrWe != '0))) begin
         mismatched++;
         $display("[TB] FAIL snap%0d@%0d: got busy=%b rd=%b wr=%b done=%b count=%0d ra=%0d wa=%0d wd=%h we=%h, required busy=%b rd=%b wr=%b done=%b count=%0d zeros=%b",
                  s.k, cyc, o.busy, o.rdEn, o.wrEn, o.done, o.wc, o.rdAddr, o.wrAddr, o.wrData, o.wrWe,
                  s.busy, s.rdEn, s.wrEn, s.done, s.wc, s.zeros);
      end
   endtask

   // Monitor: samples both instances on the falling edge and drains the scoreboards.
   always @(negedge clock) begin
      snap_t s;
      o0 = {busy0, rdEn0, wrEn0, done0, rdAddr0, wrAddr0, wrData0, wrWe0, wordCount0, cs0};
      o1 = {busy1, rdEn1, wrEn1, done1, rdAddr1, wrAddr1, wrData1, wrWe1, wordCount1, cs1};
      checkOutput(0, o0);
      checkOutput(1, o1);
      while (snapQ.size() > 0 && snapQ[0].cyc <= cyc) begin
         s = snapQ.pop_front();
         checkSnap(s, (s.k == 0) ? o0 : o1);
      end
      if (endReq && !endAck) begin
         compared++;
         if (wq0.size() + wq1.size() + dq0.size() + dq1.size() + snapQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL leftover: got %0d unconsumed expectations, required 0",
                     wq0.size() + wq1.size() + dq0.size() + dq1.size() + snapQ.size());
         end
         endAck = 1'b1;
      end
   end

   task automatic waitUntil(input int target);
      while (cyc < target) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Drives a start for one edge; base is the cycle count in which start is presented.
   task automatic applyStimulus(input int len, output int base);
      base   = cyc;
      start  = 1'b1;
      length = (AW+1)'(len);
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic pushXfer(input int base, input int len, input int nw0, input int nw1, input bit withDone);
      logic [DW-1:0] sum;
      sum = '0;
      for (int i = 0; i < len; i++) sum += mem[i];
      for (int i = 0; i < nw0; i++) wq0.push_back('{base + 2 + i, i, mem[i]});
      for (int i = 0; i < nw1; i++) wq1.push_back('{base + 3 + i, i, mem[i]});
      if (withDone) begin
         dq0.push_back('{(len == 0) ? base + 1 : base + len + 2, len, sum});
         dq1.push_back('{(len == 0) ? base + 1 : base + len + 3, len, sum});
      end
   endtask

   task automatic pushSnap(input int c, input int k, input logic b, input logic r, input logic w,
                           input logic d, input int wc, input bit z);
      snapQ.push_back('{c, k, b, r, w, d, wc, z});
   endtask

   initial begin
      int c;
      resetn = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      length = '0;
      for (int a = 0; a < 1024; a++) mem[a] = 32'hA0 + 32'(a);
      repeat (3) @(posedge clock);
      #1;
      pushSnap(cyc, 0, 0, 0, 0, 0, 0, 1);
      pushSnap(cyc, 1, 0, 0, 0, 0, 0, 1);
      waitUntil(cyc + 1);

      // L=4 straight out of reset, plus a start pulse while busy.
      resetn = 1'b1;
      applyStimulus(4, c);
      pushXfer(c, 4, 4, 4, 1);
      pushSnap(c + 1, 0, 1, 1, 0, 0, 0, 0);
      pushSnap(c + 1, 1, 1, 1, 0, 0, 0, 0);
      waitUntil(c + 2);
      start = 1'b1;
      length = 11'd2;
      waitUntil(c + 3);
      start = 1'b0;
      waitUntil(c + 8);

      // L=0 with a simultaneous abort: start wins, straight to DONE.
      abort = 1'b1;
      applyStimulus(0, c);
      pushXfer(c, 0, 0, 0, 1);
      pushSnap(c + 1, 0, 1, 0, 0, 1, 0, 0);
      pushSnap(c + 1, 1, 1, 0, 0, 1, 0, 0);
      waitUntil(c + 2);
      abort = 1'b0;
      waitUntil(c + 3);

      // L=16 aborted in the 6th READ cycle, then a clean L=2.
      applyStimulus(16, c);
      pushXfer(c, 16, 5, 4, 0);
      waitUntil(c + 6);
      abort = 1'b1;
      pushSnap(c + 7, 0, 0, 0, 0, 0, 5, 0);
      pushSnap(c + 7, 1, 0, 0, 0, 0, 4, 0);
      waitUntil(c + 7);
      abort = 1'b0;
      applyStimulus(2, c);
      pushXfer(c, 2, 2, 2, 1);
      waitUntil(c + 7);

      // Reset in the middle of an L=8 transfer, then restart with L=3.
      applyStimulus(8, c);
      pushXfer(c, 8, 3, 2, 0);
      waitUntil(c + 5);
      resetn = 1'b0;
      pushSnap(c + 5, 0, 0, 0, 0, 0, 0, 1);
      pushSnap(c + 5, 1, 0, 0, 0, 0, 0, 1);
      waitUntil(c + 7);
      resetn = 1'b1;
      pushSnap(c + 8, 0, 0, 0, 0, 0, 0, 1);
      pushSnap(c + 8, 1, 0, 0, 0, 0, 0, 1);
      waitUntil(c + 9);
      applyStimulus(3, c);
      pushXfer(c, 3, 3, 3, 1);
      waitUntil(c + 7);

      // Full-depth transfer, then an oversized length that must clamp to 1024.
      applyStimulus(1024, c);
      pushXfer(c, 1024, 1024, 1024, 1);
      pushSnap(c + 1028, 0, 0, 0, 0, 0, 1024, 0);
      pushSnap(c + 1028, 1, 0, 0, 0, 0, 1024, 0);
      waitUntil(c + 1029);
      applyStimulus(1500, c);
      pushXfer(c, 1024, 1024, 1024, 1);
      waitUntil(c + 1029);

`ifdef BRAM_XFER_CHECKSUM_EN
      mem[0] = 32'hFFFF_FFFF;
      mem[1] = 32'h0000_0001;
      mem[2] = 32'h0000_0005;
      applyStimulus(3, c);
      pushXfer(c, 3, 3, 3, 1);
      waitUntil(c + 8);
`endif

      endReq = 1'b1;
      repeat (4) @(posedge clock);
      if (!endAck) begin
         $display("[TB] FAIL monitor: final check not reached");
         $fatal(1, "[TB] monitor stalled");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bram_xfer_ctrl.md
BRAM_XFER_CTRL -- requirements
Module: bram_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, BRAM address width (1024 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, BRAM data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, source BRAM read latency in cycles (legal values 1 or 2).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, as follows:
- `clock`  in  1  sole clock; all state updates on posedge.
- `resetn`  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have these ports:
- `start`  in  1  transfer request; sampled only in IDLE.
- `length`  in  ADDR_W+1  words to move, latched on accepted start.
- `abort`  in  1  cancel the running transfer.
- `rd_addr`  out  ADDR_W  source BRAM read address.
- `rd_en`  out  1  source BRAM read enable.
- `rd_data`  in  DATA_W  source BRAM read data.
- `wr_addr`  out  ADDR_W  destination BRAM write address.
- `wr_data`  out  DATA_W  destination BRAM write data.
- `wr_en`  out  1  destination BRAM enable.
- `wr_we`  out  DATA_W/8  byte write enables.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `word_count`  out  ADDR_W+1  words written in the current or last transfer.

Function
REQ-006 The FSM SHALL have states IDLE, READ, DRAIN, DONE; the encoding is free.
REQ-007 IDLE->READ SHALL occur on start=1 with latched length L>0; start with L=0 SHALL go IDLE->DONE with no reads or writes.
REQ-008 A latched L greater than 2^ADDR_W SHALL be clamped to 2^ADDR_W.
REQ-009 In READ, rd_en SHALL be 1 and rd_addr SHALL step 0,1,...,L-1, one per cycle.
REQ-010 READ->DRAIN SHALL occur after address L-1 is issued.
REQ-011 DRAIN SHALL last exactly RD_LAT cycles, then go to DONE.
REQ-012 A read issued in cycle t SHALL produce wr_en=1, wr_we=all ones, wr_addr=that read address and wr_data=rd_data in cycle t+RD_LAT, using a RD_LAT-deep valid/address pipeline.
REQ-013 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-014 For L>0 accepted at edge T0: first write at cycle T0+1+RD_LAT; last write at T0+L+RD_LAT; done at T0+L+RD_LAT+1.
REQ-015 busy SHALL be 1 in READ, DRAIN and DONE, and 0 in IDLE.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 word_count SHALL clear on accepted start, increment per write, and hold after DONE until the next start.
REQ-018 abort=1 in READ or DRAIN SHALL force IDLE at the next edge: in-flight reads dropped, wr_en=0 from that edge, no done pulse.
REQ-019 abort in IDLE or DONE SHALL have no effect.
REQ-020 Simultaneous start and abort in IDLE SHALL accept start.
REQ-021 rd_en and wr_en SHALL be 0 whenever no valid read or write is active.
REQ-022 Address counters SHALL NOT wrap within a transfer; a full 1024-word transfer ends at address 1023.

Reset
REQ-023 resetn=0 SHALL asynchronously force IDLE and set rd_addr, wr_addr, wr_data, word_count and the valid pipeline to 0, and rd_en, wr_en, wr_we, busy, done to 0.
REQ-024 Reset mid-transfer SHALL abandon the transfer; no done pulse SHALL follow reset release.
REQ-025 The first start SHALL be accepted at the first posedge after resetn deasserts.

Configuration
REQ-026 With macro BRAM_XFER_CHECKSUM_EN defined, the block SHALL add output `checksum` (DATA_W bits): cleared on accepted start, plus wr_data added modulo 2^DATA_W per write, stable from done onward.
REQ-027 Without BRAM_XFER_CHECKSUM_EN, the `checksum` port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 start, L=4, RD_LAT=1, source data 0xA0..0xA3 -> writes at addresses 0..3 with data 0xA0..0xA3 in cycles T0+2..T0+5; done at T0+6; word_count=4.
REQ-029 start, L=0 -> done at T0+1; rd_en and wr_en never asserted; word_count=0.
REQ-030 L=1024, RD_LAT=2 -> 1024 writes, last to address 1023 at T0+1026; done at T0+1027; no wrap to address 0.
REQ-031 L=16, abort in the 6th READ cycle -> IDLE next edge, no done, word_count<=5; a new start with L=2 then completes normally.
REQ-032 resetn low mid-transfer with L=8 -> all outputs 0 immediately; restart with L=3 succeeds; start pulsed while busy is ignored.
REQ-033 BRAM_XFER_CHECKSUM_EN defined, L=3, data 0xFFFFFFFF,0x1,0x5 -> checksum=0x00000005 at done.
